nibble_add_sequencer: RTL and testbench
=======================================

# nibble_add_sequencer

Multi-precision adder/subtractor controller that time-multiplexes one 4-bit ripple adder slice across a WIDTH-bit operand, one nibble per clock, LSB first. The carry is held in a register between nibbles. Operands are accepted over a valid/ready input handshake, and the result is returned over a valid/ready output handshake. The block lets wide arithmetic in the datapath reuse the existing 4-bit adder instead of instantiating a WIDTH-bit one.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, ≥ 4. Derived: NIB = WIDTH/4.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; ignored when op_sub = 1.
- op_sub  input  1  0: A + B + c_in. 1: A − B.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result.
- c_out  output  1  final carry (for subtract: 1 = no borrow).
- ovf  output  1  two's-complement overflow.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE → RUN** on in_valid && in_ready. Capture into registers:
  - a_r = a
  - b_r = op_sub ? ~b : b
  - carry_r = op_sub ? 1 : c_in
  - idx = 0
  - sign_a_r = a[WIDTH−1]
  - sign_b_r = b_r MSB
- **RUN**, each cycle:
  - The slice adds a_r[3:0], b_r[3:0], carry_r.
  - The slice sum nibble shifts into sum_r from the top (sum_r = {nib, sum_r[WIDTH−1:4]}).
  - a_r and b_r shift right by 4. carry_r ← slice carry. idx++.
  - When idx = NIB−1, go to DONE on that edge.
- **On entry to DONE**, register the outputs:
  - c_out = final carry.
  - ovf = (sign_a_r == sign_b_r) && (sum MSB != sign_a_r).
- **DONE → IDLE** on out_ready. sum, c_out and ovf are held stable until the out_valid && out_ready handshake completes. They keep their value after leaving DONE.
- Input handling:
  - in_valid outside IDLE is ignored (in_ready = 0). The requester holds its request.
  - Changes to a, b, c_in or op_sub after acceptance have no effect.
- out_ready asserted outside DONE: no effect.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Reset (any state, any cycle):
  - state = IDLE, all registers = 0.
  - Outputs: out_valid = 0, sum = 0, c_out = 0, ovf = 0, busy = 0, in_ready = 1 (combinational from state).
  - A transaction in flight is discarded and produces no output.

## Timing
- Accept edge = E. Nibble i is processed on edge E+1+i.
- out_valid rises after edge E+NIB. Latency is NIB cycles (4 for WIDTH = 16, 1 for WIDTH = 4).
- out_valid && out_ready at edge D → IDLE after D. Earliest next accept is edge D+1.
- Peak throughput: one operation per NIB+2 cycles.
- in_ready, out_valid and busy are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Package nibble_add_pkg:
  - state typedef (IDLE/RUN/DONE).
  - localparam NIB_W = 4.
  - Function for the NIB count and idx width, $clog2(NIB) with minimum 1.
- Sub-module nibble_add_slice:
  - Purely combinational 4-bit a, b, cin → sum, cout.
  - Wraps the team's existing 4-bit ripple adder. It is the only arithmetic in the block.
- Top level contains only the FSM, shift registers, carry register, idx counter and flag logic.

## Test plan
WIDTH = 16 throughout.
- **Reset:** assert rst_n = 0 mid-clock → immediately in_ready = 1, out_valid = 0, sum = 0x0000, c_out = 0, ovf = 0, busy = 0.
- **Add with inter-nibble carry:** a = 0x00FF, b = 0x0001, c_in = 0, op_sub = 0 → sum = 0x0100, c_out = 0, ovf = 0; out_valid exactly 4 cycles after the accept edge.
- **Carry-out and overflow:**
  - a = 0xFFFF, b = 0x0001 → sum = 0x0000, c_out = 1, ovf = 0.
  - a = 0x7FFF, b = 0x0000, c_in = 1 → sum = 0x8000, c_out = 0, ovf = 1.
- **Subtract:**
  - a = 0x0005, b = 0x0007, op_sub = 1, c_in = 1 (ignored) → sum = 0xFFFE, c_out = 0.
  - a = 0x0007, b = 0x0005 → sum = 0x0002, c_out = 1.
  - a = 0x8000, b = 0x0001 → sum = 0x7FFF, ovf = 1.
- **Backpressure and ignored requests:**
  - Hold out_ready = 0 for 3 cycles in DONE → out_valid, sum and c_out stable, in_ready = 0.
  - New in_valid with a = 0x1111 during RUN → not accepted; the original result is delivered unchanged.
- **Reset mid-operation:** pulse rst_n low during RUN on nibble 2 → IDLE, out_valid never asserts for that transaction. The next transaction, a = 0x1234, b = 0x4321, gives sum = 0x5555.

Source files
------------

// File: rtl/nibble_add_pkg.sv
// ============================================================================
//  Module   : nibble_add_pkg
//  Purpose  : Shared types and sizing helpers for the nibble-serial adder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

  // Index counter width; a single-nibble operand still needs a 1-bit counter.
  function automatic int idx_width(input int width);
    int n;
    n = width / NIB_W;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_add_slice.sv
// ============================================================================
//  Module   : nibble_add_slice
//  Purpose  : Combinational 4-bit ripple-carry adder slice.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_add_slice
  import nibble_add_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  always_comb begin
    logic w_c;
    w_c  = cin;
    sum  = '0;
    for (int i = 0; i < NIB_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ w_c;
      w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    cout = w_c;
  end

endmodule

`default_nettype wire

// File: rtl/nibble_add_sequencer.sv
// ============================================================================
//  Module   : nibble_add_sequencer
//  Purpose  : WIDTH-bit add/subtract built by reusing one 4-bit slice, LSB first.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_add_sequencer
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int                 c_nib      = nib_count(WIDTH);
  localparam int                 c_idx_w    = idx_width(WIDTH);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nib - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic [c_idx_w-1:0] r_idx;
  logic               r_carry;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_c_out;
  logic               r_ovf;

  logic [WIDTH-1:0]   w_b_eff;
  logic [WIDTH-1:0]   w_sum_next;
  logic [NIB_W-1:0]   w_nib_sum;
  logic               w_nib_cout;
  logic               w_accept;
  logic               w_last;

  nibble_add_slice u_slice (
    .a    (r_a[NIB_W-1:0]),
    .b    (r_b[NIB_W-1:0]),
    .cin  (r_carry),
    .sum  (w_nib_sum),
    .cout (w_nib_cout)
  );

  // Subtraction is A + ~B + 1, so the inversion happens once at capture.
  assign w_b_eff    = op_sub ? ~b : b;
  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_last     = (r_state == ST_RUN) && (r_idx == c_last_idx);
  assign w_sum_next = (r_sum >> NIB_W) | (WIDTH'(w_nib_sum) << (WIDTH - NIB_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (r_idx == c_last_idx) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_c_out  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= w_b_eff;
      r_carry  <= op_sub ? 1'b1 : c_in;
      r_idx    <= '0;
      r_sign_a <= a[WIDTH-1];
      r_sign_b <= w_b_eff[WIDTH-1];
    end else if (r_state == ST_RUN) begin
      r_sum   <= w_sum_next;
      r_a     <= r_a >> NIB_W;
      r_b     <= r_b >> NIB_W;
      r_carry <= w_nib_cout;
      r_idx   <= r_idx + c_idx_w'(1);
      // The last slice nibble is the result MSB nibble, so flags come straight off it.
      if (w_last) begin
        r_c_out <= w_nib_cout;
        r_ovf   <= (r_sign_a == r_sign_b) && (w_nib_sum[NIB_W-1] != r_sign_a);
      end
    end
  end

  assign sum   = r_sum;
  assign c_out = r_c_out;
  assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_nibble_add_sequencer.sv
// ============================================================================
//  Module   : tb_nibble_add_sequencer
//  Purpose  : Directed self-checking bench for nibble_add_sequencer (WIDTH=16).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_add_sequencer;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  nibble_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents operands in IDLE, returns 1ns after the accept edge with garbage on the inputs.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic sb);
    @(negedge clk);
    a = av; b = bv; c_in = ci; op_sub = sb; in_valid = 1'b1;
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; c_in = ~ci; op_sub = ~sb;
  endtask

  // Counts edges after the accept edge until out_valid is seen, bounded.
  task automatic wait_result(output int k);
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end while (!out_valid && k < 20);
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb,
                        input logic [15:0] es, input logic ec, input logic eo);
    int k;
    start_op(av, bv, ci, sb);
    wait_result(k);
    chk({tag, "_latency"}, k, 32'd4);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
    chk({tag, "_c_out"}, {31'd0, c_out}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_after_hs"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid_low"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_sum_held"}, {16'd0, sum}, {16'd0, es});
  endtask

  initial begin
    int k;
    int seen;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; op_sub = 1'b0;

    // Asynchronous reset asserted mid-cycle takes effect without a clock edge.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'h0000);
    chk("rst_c_out", {31'd0, c_out}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_carry_chain", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("add_wrap",        16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf_cin",     16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_borrow",      16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_no_borrow",   16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("sub_ovf",         16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Second request during RUN is ignored; result is held under backpressure.
    start_op(16'h1234, 16'h0F0F, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; c_in = 1'b1; op_sub = 1'b0; in_valid = 1'b1;
    chk("bp_in_ready_run", {31'd0, in_ready}, 32'd0);
    wait_result(k);
    chk("bp_latency", k, 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("bp_sum_hold", {16'd0, sum}, 32'h2143);
      chk("bp_c_out_hold", {31'd0, c_out}, 32'd0);
      chk("bp_in_ready_done", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_sum_after", {16'd0, sum}, 32'h2143);
    @(posedge clk);
    @(negedge clk);
    chk("bp_stays_idle", {31'd0, busy}, 32'd0);

    // Reset pulse between nibble 1 and nibble 2 discards the transaction.
    start_op(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_sum", {16'd0, sum}, 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_no_out_valid", seen, 32'd0);

    run_op("after_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
